// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, bit/edge counting, deserialization,
// parity and stop checking with one registered result pulse per frame.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [7:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_data,
  input  logic                  samp_valid,
  output logic                  samp_en,
  output logic [15:0]           edge_count,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BIT_W    = 4;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, next_state;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       pre_r;
  logic             par_en_r, par_typ_r;
  logic             par_bad, stp_bad;
  logic             wrap_c, pre_wrap_c, start_c, fire_c, stp_now_c, par_exp_c;

  // wrap closes a bit; pre_wrap is one cycle earlier so registered results land on the wrap cycle
  assign wrap_c     = (edge_count == CNT_W'(pre_r) - CNT_W'(1));
  assign pre_wrap_c = (edge_count == CNT_W'(pre_r) - CNT_W'(2));
  assign start_c    = (state == IDLE) && !rx_in;
  assign fire_c     = (state == STOP) && pre_wrap_c;
  assign stp_now_c  = samp_valid ? ~sampled_data : stp_bad;
  assign par_exp_c  = (^p_data) ^ par_typ_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_in) next_state = START;
      START: begin
        if (samp_valid && sampled_data) next_state = IDLE;
        else if (wrap_c)                next_state = DATA;
      end
      DATA:    if (wrap_c && bit_cnt == LAST_BIT) next_state = par_en_r ? PARITY : STOP;
      PARITY:  if (wrap_c) next_state = STOP;
      STOP:    if (wrap_c) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_en    <= 1'b0;
      edge_count <= '0;
      bit_cnt    <= '0;
      pre_r      <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      samp_en <= (next_state != IDLE);

      if (state == IDLE || next_state == IDLE || wrap_c) edge_count <= '0;
      else                                               edge_count <= edge_count + CNT_W'(1);

      if (state == IDLE)                                        bit_cnt <= '0;
      else if (state == DATA && wrap_c && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + BIT_W'(1);

      // frame configuration is frozen at start detection
      if (start_c) begin
        pre_r     <= prescale;
        par_en_r  <= par_en;
        par_typ_r <= par_typ;
        par_bad   <= 1'b0;
        stp_bad   <= 1'b0;
      end

      if (state == DATA && samp_valid)   p_data  <= {sampled_data, p_data[DATA_WIDTH-1:1]};
      if (state == PARITY && samp_valid) par_bad <= (sampled_data != par_exp_c);
      if (state == STOP && samp_valid)   stp_bad <= ~sampled_data;

      // stop sample may coincide with pre_wrap at the smallest prescale, hence the bypass
      data_valid <= fire_c && !par_bad && !stp_now_c;
      par_err    <= fire_c && par_bad;
      stp_err    <= fire_c && stp_now_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized bench for uart_rx_fsm: drives serial frames, models the sampler,
// and checks every cycle against frame timing derived from bit positions.
module tb_uart_rx_fsm;

  logic        clk = 1'b0;
  logic        rst, rx_in, par_en, par_typ;
  logic        sampled_data, samp_valid, samp_en;
  logic        data_valid, par_err, stp_err;
  logic [7:0]  prescale, p_data;
  logic [15:0] edge_count, samp_pt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // sampler stand-in: rx_in is held for a whole bit, so its value is the vote
  assign samp_valid   = samp_en && (edge_count == samp_pt);
  assign sampled_data = rx_in;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .sampled_data(sampled_data),
    .samp_valid(samp_valid), .samp_en(samp_en), .edge_count(edge_count),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_samp_en"}, 32'(samp_en), 32'd0);
    check_eq({tag, "_edge"}, 32'(edge_count), 32'd0);
    check_eq({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_idle(tag);
    check_eq({tag, "_p_data"}, 32'(p_data), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      #1 rx_in = 1'b1;
      prescale = 8'($urandom);
      @(negedge clk);
      check_idle("idle");
      @(posedge clk);
    end
  endtask

  // One frame starting from IDLE; entered and left just after a rising edge.
  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                            input bit bad_par, input bit stop_bit, input int abort_at = -1);
    int n;
    bit pbit, b, last;
    n    = (10 + int'(pe)) * p;
    pbit = (^d) ^ pt ^ bad_par;
    #1 rx_in = 1'b0;
    prescale = 8'(p);
    par_en   = pe;
    par_typ  = pt;
    samp_pt  = 16'(p / 2 + 2);
    @(negedge clk);
    check_idle("detect");
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      int k;
      k = c / p;
      if (k == 0)             b = 1'b0;
      else if (k <= 8)        b = d[k-1];
      else if (k == 9 && pe)  b = pbit;
      else                    b = stop_bit;
      #1 rx_in = b;
      prescale = 8'($urandom);
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      if (c == abort_at) begin
        rst = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk);
        #1 check_all_zero("rst_held");
        @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        return;
      end
      @(negedge clk);
      last = (c == n - 1);
      check_eq("samp_en", 32'(samp_en), 32'd1);
      check_eq("edge_count", 32'(edge_count), 32'(c % p));
      check_eq("data_valid", 32'(data_valid), 32'(last && !(pe && bad_par) && stop_bit));
      check_eq("par_err", 32'(par_err), 32'(last && pe && bad_par));
      check_eq("stp_err", 32'(stp_err), 32'(last && !stop_bit));
      if (last) check_eq("p_data", 32'(p_data), 32'(d));
      @(posedge clk);
    end
  endtask

  // Line low for three cycles only; sampler sees 1 and the frame is abandoned.
  task automatic false_start();
    #1 rx_in = 1'b0;
    prescale = 8'd16;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    samp_pt  = 16'd10;
    @(negedge clk);
    check_idle("fs_detect");
    @(posedge clk);
    for (int c = 0; c < 14; c++) begin
      #1 rx_in = (c < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c <= 10) begin
        check_eq("fs_samp_en", 32'(samp_en), 32'd1);
        check_eq("fs_edge", 32'(edge_count), 32'(c));
        check_eq("fs_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      end else begin
        check_idle("fs_back_idle");
      end
      @(posedge clk);
    end
  endtask

  initial begin
    int p;
    bit pe, pt, bp, sb;
    logic [7:0] d;
    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 8'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    samp_pt  = 16'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    idle(2);

    send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    idle(3);
    check_eq("p_data_hold", 32'(p_data), 32'hA5);

    send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
    send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    idle(1);
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    send_frame(8, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    idle(1);

    false_start();
    idle(2);

    send_frame(32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    idle(2);

    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 4 * 8 + 4);
    idle(3);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
    idle(1);

    repeat (24) begin
      p  = 2 * int'($urandom_range(4, 40));
      pe = 1'($urandom);
      pt = 1'($urandom);
      d  = 8'($urandom);
      bp = pe && ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(p, pe, pt, d, bp, sb);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
